// File: rtl/switch_alu_pkg.sv
// Shared op codes, FSM state encoding and the ALU function for the switch/key console.
package switch_alu_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_XOR = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SHOW_A   = 2'd1,
    ST_SHOW_B   = 2'd2,
    ST_SHOW_RES = 2'd3
  } state_t;

  localparam int ALU_MAX_W = 32;

  // Operands arrive zero-extended; the caller keeps the low W+1 bits, which yields
  // carry for ADD and borrow (A-B mod 2^(W+1)) for SUB at any width up to ALU_MAX_W.
  function automatic logic [ALU_MAX_W:0] alu_f(input logic [ALU_MAX_W-1:0] a,
                                               input logic [ALU_MAX_W-1:0] b,
                                               input op_t op);
    logic [ALU_MAX_W:0] ax;
    logic [ALU_MAX_W:0] bx;
    ax = {1'b0, a};
    bx = {1'b0, b};
    case (op)
      OP_ADD:  return ax + bx;
      OP_SUB:  return ax - bx;
      OP_AND:  return ax & bx;
      default: return ax ^ bx;
    endcase
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Active-low key conditioner: 2-FF synchroniser, stable-level debounce counter and a
// one-clock press pulse on the accepted 1->0 transition.
module key_debounce #(
  parameter int DEBOUNCE_CYC = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

  logic [1:0]    sync_q;
  logic          level;
  logic          armed;
  logic [CW-1:0] cnt;
  logic          settled;

  assign settled = (cnt == CW'(DEBOUNCE_CYC - 1));

  // Until the synced key has been seen released, nothing counts: a key held through
  // reset must be released and pressed again before it produces an event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
      level  <= 1'b1;
      armed  <= 1'b0;
      cnt    <= '0;
      press  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values,
      // so the synchroniser stages and the counter update in parallel as in hardware.
      sync_q <= {sync_q[0], key};
      press  <= 1'b0;
      if (!armed) begin
        armed <= sync_q[1];
        cnt   <= '0;
      end else if (sync_q[1] == level) begin
        cnt <= '0;
      end else if (settled) begin
        level <= sync_q[1];
        cnt   <= '0;
        press <= ~sync_q[1];
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/switch_alu_console.sv
// Operand-entry console: keys load A/B from the switches and execute a 4-op ALU onto LEDs.
// W must not exceed switch_alu_pkg::ALU_MAX_W.
module switch_alu_console
  import switch_alu_pkg::*;
#(
  parameter int W            = 4,
  parameter int DEBOUNCE_CYC = 50000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] i_switch,
  input  logic [1:0]   i_op,
  input  logic         key0,
  input  logic         key1,
  input  logic         key2,
  output logic [W:0]   o_LED,
  output logic [1:0]   o_state,
  output logic         o_err
);

  localparam int LED_W = W + 1;

  logic [1:0]   rst_q;
  logic         rst_sync_n;
  logic [W-1:0] sw_q1, sw_q2;
  logic [1:0]   op_q1, op_q2;
  logic         ev0, ev1, ev2;
  state_t       state;
  logic [W-1:0] a, b;
  logic         a_vld, b_vld;

  // NOTE: reset asserts asynchronously but releases on a clock edge, so no flop sees
  // rst_n deassert close to its active edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_q <= 2'b00;
    else        rst_q <= {rst_q[0], 1'b1};
  end
  assign rst_sync_n = rst_q[1];

  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      sw_q1 <= '0;
      sw_q2 <= '0;
      op_q1 <= '0;
      op_q2 <= '0;
    end else begin
      sw_q1 <= i_switch;
      sw_q2 <= sw_q1;
      op_q1 <= i_op;
      op_q2 <= op_q1;
    end
  end

  key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_key0 (
    .clk(clk), .rst_n(rst_sync_n), .key(key0), .press(ev0));
  key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_key1 (
    .clk(clk), .rst_n(rst_sync_n), .key(key1), .press(ev1));
  key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_key2 (
    .clk(clk), .rst_n(rst_sync_n), .key(key2), .press(ev2));

  // Same-cycle events resolve key0 > key1 > key2; the losers are discarded.
  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      state <= ST_IDLE;
      a     <= '0;
      b     <= '0;
      a_vld <= 1'b0;
      b_vld <= 1'b0;
      o_LED <= '0;
      o_err <= 1'b0;
    end else if (ev0) begin
      a     <= sw_q2;
      a_vld <= 1'b1;
      o_LED <= {1'b0, sw_q2};
      state <= ST_SHOW_A;
      o_err <= 1'b0;
    end else if (ev1) begin
      b     <= sw_q2;
      b_vld <= 1'b1;
      o_LED <= {1'b0, sw_q2};
      state <= ST_SHOW_B;
      o_err <= 1'b0;
    end else if (ev2) begin
      if (a_vld && b_vld) begin
        o_LED <= LED_W'(alu_f(ALU_MAX_W'(a), ALU_MAX_W'(b), op_t'(op_q2)));
        state <= ST_SHOW_RES;
        o_err <= 1'b0;
      end else begin
        o_err <= 1'b1;
      end
    end
  end

  assign o_state = state;

endmodule
